ddr_rx_frame_aligner: RTL and testbench

Downstream consumer of the DDR input receiver. It takes the 2-bit SDR lane pair produced each `clk_buf_i` cycle, treats it as a serial bit stream, and finds byte and frame boundaries using a periodic sync byte. Once locked, it emits payload bytes with a valid strobe and a start-of-frame flag. It tolerates isolated sync corruption by continuing to count frames without re-hunting ("flywheel").

---
 rtl/ddr_rx_pkg.sv | 8 +
 rtl/ddr_rx_frame_aligner_sync_detect.sv | 27 ++
 rtl/ddr_rx_frame_aligner.sv | 134 +++++++++++++
 tb/tb_ddr_rx_frame_aligner.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/ddr_rx_pkg.sv
// ddr_rx_pkg: shared types and helpers for the DDR receive frame aligner
package ddr_rx_pkg;
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  localparam logic [7:0] DEFAULT_SYNC = 8'hA5;
  function automatic int bidx_w(input int fb);
    return (fb < 2) ? 1 : $clog2(fb);
  endfunction
endpackage

// File: rtl/ddr_rx_frame_aligner_sync_detect.sv
// ddr_rx_sync_detect: bit history plus even/odd sync-byte window comparators
module ddr_rx_sync_detect
  import ddr_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC
) (
  input  logic       clk_buf_i,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] data_i,
  output logic       match_even,
  output logic       match_odd,
  output logic [7:0] win_even,
  output logic [7:0] win_odd
);
  logic [6:0] hist;
  logic [8:0] sr;
  assign sr         = {hist, data_i[0], data_i[1]};
  assign win_even   = sr[7:0];
  assign win_odd    = sr[8:1];
  assign match_even = win_even == SYNC_BYTE;
  assign match_odd  = win_odd == SYNC_BYTE;
  // keep the last 7 bits so the windows always see this cycle's pair as the newest bits
  always_ff @(posedge clk_buf_i or negedge reset_n)
    if (!reset_n) hist <= '0;
    else if (enable) hist <= sr[6:0];
endmodule

// File: rtl/ddr_rx_frame_aligner.sv
// ddr_rx_frame_aligner: byte/frame alignment on a 2-bit lane stream with flywheel lock
module ddr_rx_frame_aligner
  import ddr_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC,
  parameter int         FRAME_BYTES  = 16,
  parameter int         LOCK_COUNT   = 2,
  parameter int         UNLOCK_COUNT = 2
) (
  input  logic       clk_buf_i,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       sof_o,
  output logic       locked_o,
  output logic       sync_err_o
);
  localparam int BW = bidx_w(FRAME_BYTES);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int UW = $clog2(UNLOCK_COUNT + 1);
  localparam logic [BW-1:0] LAST = BW'(FRAME_BYTES - 1);
  state_t          state, state_n;
  logic            phase, phase_n;
  logic [1:0]      cyc, cyc_n;
  logic [BW-1:0]   bidx, bidx_n;
  logic [GW-1:0]   good, good_n;
  logic [UW-1:0]   bad, bad_n;
  logic [7:0]      byte_n, win_even, win_odd, win;
  logic            valid_n, sof_n, err_n, match_even, match_odd, done, hit;
  ddr_rx_sync_detect #(.SYNC_BYTE(SYNC_BYTE)) u_det (
    .clk_buf_i (clk_buf_i),
    .reset_n   (reset_n),
    .enable    (enable),
    .data_i    (data_i),
    .match_even(match_even),
    .match_odd (match_odd),
    .win_even  (win_even),
    .win_odd   (win_odd)
  );
  assign win      = phase ? win_odd : win_even;
  assign hit      = win == SYNC_BYTE;
  assign done     = enable && cyc == 2'd3;
  assign locked_o = state == LOCKED;
  // next-state, counters and output strobes; everything holds while enable is low
  always_comb begin
    state_n = state;
    phase_n = phase;
    cyc_n   = cyc;
    bidx_n  = bidx;
    good_n  = good;
    bad_n   = bad;
    byte_n  = byte_o;
    valid_n = 1'b0;
    sof_n   = 1'b0;
    err_n   = 1'b0;
    if (enable) begin
      cyc_n = (state == HUNT) ? 2'd0 : cyc + 2'd1;
      if (done && state != HUNT) bidx_n = (bidx == LAST) ? '0 : bidx + BW'(1);
      unique case (state)
        HUNT:
          if (match_even || match_odd) begin
            state_n = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
            phase_n = !match_even;
            bidx_n  = BW'(1);
            good_n  = GW'(1);
            bad_n   = '0;
          end
        VERIFY:
          if (done && bidx == '0) begin
            if (hit) begin
              good_n = good + GW'(1);
              if (int'(good) + 1 >= LOCK_COUNT) begin
                state_n = LOCKED;
                bad_n   = '0;
              end
            end else begin
              state_n = HUNT;
              cyc_n   = '0;
              bidx_n  = '0;
              good_n  = '0;
            end
          end
        LOCKED:
          if (done) begin
            if (bidx != '0) begin
              valid_n = 1'b1;
              sof_n   = bidx == BW'(1);
              byte_n  = win;
            end else if (hit) begin
              bad_n = '0;
            end else begin
              err_n = 1'b1;
              bad_n = bad + UW'(1);
              if (int'(bad) + 1 >= UNLOCK_COUNT) begin
                state_n = HUNT;
                cyc_n   = '0;
                bidx_n  = '0;
                good_n  = '0;
                bad_n   = '0;
              end
            end
          end
        default: state_n = HUNT;
      endcase
    end
  end
  // state, counters and registered outputs; async reset always drops lock
  always_ff @(posedge clk_buf_i or negedge reset_n)
    if (!reset_n) begin
      state        <= HUNT;
      phase        <= 1'b0;
      cyc          <= '0;
      bidx         <= '0;
      good         <= '0;
      bad          <= '0;
      byte_o       <= '0;
      byte_valid_o <= 1'b0;
      sof_o        <= 1'b0;
      sync_err_o   <= 1'b0;
    end else begin
      state        <= state_n;
      phase        <= phase_n;
      cyc          <= cyc_n;
      bidx         <= bidx_n;
      good         <= good_n;
      bad          <= bad_n;
      byte_o       <= byte_n;
      byte_valid_o <= valid_n;
      sof_o        <= sof_n;
      sync_err_o   <= err_n;
    end
endmodule

// File: tb/tb_ddr_rx_frame_aligner.sv
// tb_ddr_rx_frame_aligner: table-driven directed checks of the frame aligner
module tb_ddr_rx_frame_aligner;
  logic       clk_buf_i = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] data_i = '0;
  logic [7:0] byte_o;
  logic       byte_valid_o, sof_o, locked_o, sync_err_o;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         pre;
    bit         fake;
    int         nfr;
    logic [7:0] bad;
    int         gap_at;
    int         rst_at;
    int         lock_at;
    int         strobes;
    int         errs;
    bit         locked;
    bit         phase;
  } vec_t;
  vec_t tv[7];

  ddr_rx_frame_aligner dut (
    .clk_buf_i   (clk_buf_i),
    .reset_n     (reset_n),
    .enable      (enable),
    .data_i      (data_i),
    .byte_o      (byte_o),
    .byte_valid_o(byte_valid_o),
    .sof_o       (sof_o),
    .locked_o    (locked_o),
    .sync_err_o  (sync_err_o)
  );

  always #5 clk_buf_i = ~clk_buf_i;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " byte_o"}, byte_o, 0);
    chk({tag, " byte_valid_o"}, byte_valid_o, 0);
    chk({tag, " sof_o"}, sof_o, 0);
    chk({tag, " locked_o"}, locked_o, 0);
    chk({tag, " sync_err_o"}, sync_err_o, 0);
  endtask

  task automatic run(input int id, input vec_t v);
    bit         bq[$];
    logic [7:0] bytes[$];
    logic [7:0] b;
    int n, k, gap, strobes, errs, lock_at, late, exp_b;
    bit unl, fall_err;
    string t;
    t = $sformatf("v%0d", id);
    if (v.fake) begin
      bytes.push_back(8'h33);
      bytes.push_back(8'hA5);
      bytes.push_back(8'h33);
      bytes.push_back(8'h33);
    end
    for (int f = 0; f < v.nfr; f++) begin
      bytes.push_back(v.bad[f] ? 8'hA4 : 8'hA5);
      for (int p = 1; p < 16; p++) bytes.push_back(8'(p));
    end
    for (int p = 0; p < v.pre; p++) bq.push_back(1'($urandom_range(0, 1)));
    foreach (bytes[j]) begin
      b = bytes[j];
      for (int q = 7; q >= 0; q--) bq.push_back(b[q]);
    end
    if (bq.size() % 2 != 0) bq.push_back(1'b0);
    enable  = 1'b0;
    data_i  = '0;
    reset_n = 1'b0;
    @(posedge clk_buf_i);
    #1 reset_n = 1'b1;
    n = 0; k = 0; gap = 0; strobes = 0; errs = 0; lock_at = 0; late = 0;
    exp_b = 1; unl = 0; fall_err = 0;
    while (k < bq.size()) begin
      if (n == v.gap_at && gap < 5) begin
        enable = 1'b0;
        data_i = 2'($urandom_range(0, 3));
        gap++;
      end else begin
        enable = 1'b1;
        data_i = {bq[k+1], bq[k]};
        k += 2;
      end
      @(posedge clk_buf_i);
      #1;
      if (enable) n++;
      else chk({t, " gap strobe"}, byte_valid_o, 0);
      if (byte_valid_o) begin
        strobes++;
        if (unl) late++;
        chk($sformatf("%s byte@%0d", t, n), byte_o, exp_b);
        chk($sformatf("%s sof@%0d", t, n), sof_o, exp_b == 1);
        exp_b = (exp_b == 15) ? 1 : exp_b + 1;
      end
      if (sync_err_o) errs++;
      if (locked_o && lock_at == 0) lock_at = n;
      if (lock_at != 0 && !locked_o && !unl) begin
        unl = 1;
        fall_err = sync_err_o;
      end
      if (enable && n == v.rst_at) begin
        #2 reset_n = 1'b0;
        #1 chk_zero({t, " async reset"});
        reset_n = 1'b1;
        lock_at = 0;
        exp_b = 1;
      end
    end
    enable = 1'b0;
    repeat (3) @(posedge clk_buf_i);
    #1;
    chk({t, " lock cycle"}, lock_at, v.lock_at);
    chk({t, " strobes"}, strobes, v.strobes);
    chk({t, " sync errs"}, errs, v.errs);
    chk({t, " locked end"}, locked_o, v.locked);
    chk({t, " lock dropped"}, unl, !v.locked);
    chk({t, " phase"}, dut.phase, v.phase);
    chk({t, " strobes after unlock"}, late, 0);
    if (!v.locked) chk({t, " unlock with err"}, fall_err, 1);
  endtask

  initial begin
    //        pre fake nfr bad         gap  rst  lock strb errs lkd ph
    tv[0] = '{0,  0,   3,  8'b0000_0000, -1, -1,  68,  30,  0,   1,  0};
    tv[1] = '{3,  0,   3,  8'b0000_0000, -1, -1,  70,  30,  0,   1,  1};
    tv[2] = '{0,  0,   5,  8'b0000_1000, -1, -1,  68,  60,  1,   1,  0};
    tv[3] = '{0,  0,   6,  8'b0001_1000, -1, -1,  68,  45,  2,   0,  0};
    tv[4] = '{0,  1,   4,  8'b0000_0000, -1, -1,  148, 30,  0,   1,  0};
    tv[5] = '{0,  0,   3,  8'b0000_0000, 102, -1, 68,  30,  0,   1,  0};
    tv[6] = '{0,  0,   4,  8'b0000_0000, -1, 96,  196, 22,  0,   1,  0};
    #3 chk_zero("reset");
    for (int i = 0; i < 7; i++) run(i, tv[i]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
